// File: rtl/adder_tree_sched_pkg.sv
// adder_tree_sched shared types: FSM state enum, tree lane count,
// and the accumulator width derivation.
package adder_tree_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN,
        OUT
    } state_e;

    localparam int LANES = 8;

    // Tree output is aw+3 bits; accumulating mb beats adds log2(mb) bits.
    function automatic int acc_width(input int aw, input int mb);
        return aw + 3 + $clog2(mb);
    endfunction

endpackage

// File: rtl/adder_tree_sched_tree.sv
// reduce_tree8: combinational 8-lane unsigned sum, +1 bit per level.
// Ports: lanes (8 x W, lane 0 at LSBs) -> sum (W+3 bits).
module reduce_tree8
    import adder_tree_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [LANES*W-1:0] lanes,
    output logic [W+2:0]       sum
);

    logic [W:0]   l1 [4];
    logic [W+1:0] l2 [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            l1[i] = {1'b0, lanes[(2*i)*W +: W]}
                  + {1'b0, lanes[(2*i+1)*W +: W]};
        end
        for (int j = 0; j < 2; j++) begin
            l2[j] = {1'b0, l1[2*j]} + {1'b0, l1[2*j+1]};
        end
        sum = {1'b0, l2[0]} + {1'b0, l2[1]};
    end

endmodule

// File: rtl/adder_tree_sched.sv
// adder_tree_sched: round-robin share of one 8-lane adder tree.
// Ports: req_valid/ready/data/last per requester in; res_* tagged
// burst total out on a valid/ready port. clk, async reset_n.
module adder_tree_sched
    import adder_tree_sched_pkg::*;
#(
    parameter int ADDER_WIDTH = 8,
    parameter int NUM_REQ     = 4,
    parameter int MAX_BEATS   = 16,
    localparam int ACC_WIDTH  = acc_width(ADDER_WIDTH, MAX_BEATS),
    localparam int IDW        = $clog2(NUM_REQ),
    localparam int BW         = $clog2(MAX_BEATS) + 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*LANES*ADDER_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [ACC_WIDTH-1:0]               res_sum,
    output logic [IDW-1:0]                     res_id,
    output logic [BW-1:0]                      res_beats,
    output logic                               res_trunc
);

    localparam int LW = LANES * ADDER_WIDTH;
    localparam int TW = ADDER_WIDTH + 3;

    state_e               state_q, state_d;
    logic [IDW-1:0]       rr_ptr, grant_id, pick;
    logic                 found;
    logic [BW-1:0]        beat_cnt;
    logic [LW-1:0]        s1_lanes;
    logic                 s1_valid, s1_first;
    logic [ACC_WIDTH-1:0] acc;
    logic                 trunc_q;
    logic [TW-1:0]        tree_sum;
    logic [LW-1:0]        lanes_arr [NUM_REQ];
    logic [LW-1:0]        grant_lanes;
    logic                 accept, hit_max, last_in;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            lanes_arr[r] = req_data[r*LW +: LW];
        end
    end

    assign grant_lanes = lanes_arr[grant_id];
    assign last_in     = req_last[grant_id];
    assign accept      = (state_q == BURST) && req_valid[grant_id];
    assign hit_max     = (beat_cnt == BW'(MAX_BEATS - 1));

    // First valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    reduce_tree8 #(.W(ADDER_WIDTH)) u_tree (
        .lanes (s1_lanes),
        .sum   (tree_sum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        res_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) state_d = BURST;
            end
            BURST: begin
                req_ready[grant_id] = 1'b1;
                if (accept && (last_in || hit_max)) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            s1_lanes <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            acc      <= '0;
            trunc_q  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_lanes <= grant_lanes;
                s1_first <= (beat_cnt == '0);
                beat_cnt <= beat_cnt + BW'(1);
                // Limit hit on the same beat as last is a normal end.
                if (last_in)      trunc_q <= 1'b0;
                else if (hit_max) trunc_q <= 1'b1;
            end
            // First beat loads, so no separate clear between bursts.
            if (s1_valid) begin
                acc <= s1_first ? ACC_WIDTH'(tree_sum)
                                : acc + ACC_WIDTH'(tree_sum);
            end
            if (state_q == IDLE && found) begin
                grant_id <= pick;
                beat_cnt <= '0;
                trunc_q  <= 1'b0;
            end
            if (state_q == OUT && res_ready) begin
                rr_ptr <= (grant_id == IDW'(NUM_REQ - 1))
                        ? '0 : grant_id + IDW'(1);
            end
        end
    end

    assign res_sum   = acc;
    assign res_id    = grant_id;
    assign res_beats = beat_cnt;
    assign res_trunc = trunc_q;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed + randomized bench for adder_tree_sched at defaults,
// checked against a burst-sum / round-robin reference model.
module tb_adder_tree_sched;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [255:0] req_data = '0;
    logic [3:0]   req_last = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [14:0]  res_sum;
    logic [1:0]   res_id;
    logic [4:0]   res_beats;
    logic         res_trunc;

    int checks = 0;
    int failures = 0;
    int exp_ptr = 0;

    always #5 clk = ~clk;

    adder_tree_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_last  (req_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_beats (res_beats),
        .res_trunc (res_trunc)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lanesum(input logic [63:0] d);
        int s = 0;
        for (int i = 0; i < 8; i++) s += int'(d[i*8 +: 8]);
        return s;
    endfunction

    function automatic int exp_grant(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[(exp_ptr + i) % 4]) return (exp_ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Present one beat and return at the negedge after it is taken.
    task automatic drive_beat(input logic [1:0] r, input logic [63:0] d,
                              input bit last);
        int guard = 0;
        req_valid[r] = 1'b1;
        req_data[r*64 +: 64] = d;
        req_last[r] = last;
        while (req_ready[r] !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("beat_wait", 64'(guard < 40), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
        req_last[r] = 1'b0;
    endtask

    task automatic take_result(input int s, input logic [1:0] id,
                               input int beats, input bit tr,
                               input int stall);
        int guard = 0;
        while (res_valid !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("res_wait", 64'(guard < 40), 64'd1);
        chk("res_sum", 64'(res_sum), 64'(s));
        chk("res_id", 64'(res_id), 64'(id));
        chk("res_beats", 64'(res_beats), 64'(beats));
        chk("res_trunc", 64'(res_trunc), 64'(tr));
        chk("out_ready", 64'(req_ready), 64'd0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_valid", 64'(res_valid), 64'd1);
            chk("stall_sum", 64'(res_sum), 64'(s));
            chk("stall_id", 64'(res_id), 64'(id));
            chk("stall_ready", 64'(req_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_drop", 64'(res_valid), 64'd0);
        exp_ptr = (int'(id) + 1) % 4;
    endtask

    initial begin
        logic [63:0] d, d2;
        logic [1:0]  r;
        int          n, s, g, guard;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_sum", 64'(res_sum), 64'd0);
        chk("rst_beats", 64'(res_beats), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single full-scale beat and result latency
        d = '1;
        drive_beat(2'd2, d, 1'b1);
        chk("lat_c1", 64'(res_valid), 64'd0);
        @(negedge clk);
        chk("lat_c2", 64'(res_valid), 64'd1);
        take_result(2040, 2'd2, 1, 1'b0, 0);

        // Three beats with a bubble
        drive_beat(2'd0, {8{8'd1}}, 1'b0);
        @(negedge clk);
        drive_beat(2'd0, {8{8'd2}}, 1'b0);
        drive_beat(2'd0, {8{8'd3}}, 1'b1);
        take_result(48, 2'd0, 3, 1'b0, 0);

        // Reset mid-burst
        drive_beat(2'd3, rnd64(), 1'b0);
        drive_beat(2'd3, rnd64(), 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_sum", 64'(res_sum), 64'd0);
        chk("mid_rst_id", 64'(res_id), 64'd0);
        chk("mid_rst_beats", 64'(res_beats), 64'd0);
        chk("mid_rst_trunc", 64'(res_trunc), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_ptr = 0;
        @(negedge clk);
        d = rnd64();
        d2 = rnd64();
        drive_beat(2'd3, d, 1'b0);
        drive_beat(2'd3, d2, 1'b1);
        take_result(lanesum(d) + lanesum(d2), 2'd3, 2, 1'b0, 0);

        // All requesters valid, single-beat bursts
        for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = rnd64();
        req_valid = 4'hF;
        req_last = 4'hF;
        for (int k = 0; k < 5; k++) begin
            guard = 0;
            while (req_ready === 4'h0 && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            chk("rr_wait", 64'(guard < 40), 64'd1);
            chk("rr_onehot", 64'($countones(req_ready)), 64'd1);
            g = 0;
            for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
            chk("rr_grant", 64'(g), 64'(exp_grant(4'hF)));
            s = lanesum(req_data[g*64 +: 64]);
            @(posedge clk);
            @(negedge clk);
            chk("rr_drain_ready", 64'(req_ready), 64'd0);
            take_result(s, 2'(g), 1, 1'b0, 0);
            if (k == 4) begin
                req_valid = '0;
                req_last = '0;
            end
            req_data[g*64 +: 64] = rnd64();
        end

        // Truncated 16-beat burst, then grant moves on
        d = '1;
        d2 = rnd64();
        for (int b = 0; b < 16; b++) begin
            if (b == 15) begin
                req_valid[2] = 1'b1;
                req_data[2*64 +: 64] = d2;
                req_last[2] = 1'b1;
            end
            drive_beat(2'd1, d, 1'b0);
        end
        chk("trunc_drain_ready", 64'(req_ready), 64'd0);
        req_valid[1] = 1'b1;
        take_result(32640, 2'd1, 16, 1'b1, 0);
        guard = 0;
        while (req_ready === 4'h0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("post_trunc_grant", 64'(req_ready),
            64'(4'b0001 << exp_grant(4'b0110)));
        req_valid[1] = 1'b0;

        // Result stalled five cycles
        drive_beat(2'd2, d2, 1'b1);
        take_result(lanesum(d2), 2'd2, 1, 1'b0, 5);

        // Randomized bursts
        for (int t = 0; t < 6; t++) begin
            r = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 6);
            s = 0;
            for (int b = 0; b < n; b++) begin
                d = rnd64();
                s += lanesum(d);
                drive_beat(r, d, b == n - 1);
                if (b < n - 1 && $urandom_range(0, 1) == 1) @(negedge clk);
            end
            take_result(s, r, n, 1'b0, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
